rand_serializer: RTL and testbench
==================================

# rand_serializer

Word-to-bit serializer for the random-number subsystem: accepts `ws`-bit words from a generator such as the LN map source, buffers them in a small FIFO, and emits them one bit per clock, LSB first. Each serial word is a frame of `ws` consecutive bits. It is the transmit counterpart of the bit-collecting random sources, which fill bit 0 first. It feeds downstream bit-serial consumers (pins, whitening stages, capture logic), and packed words can be replayed through it into the bit-collecting sources for loopback checks.

## Interface
- `ws`, 16: word width and frame length in bits; must be ≥ 2.
- `DEPTH`, 4: FIFO depth in words; must be a power of two ≥ 2.
- `AW`, 2: log2(`DEPTH`).
- `iCLK`  in  1: single clock; all state updates on the falling edge.
- `iRST_N`  in  1: reset, asynchronous, active-low.
- `iData`  in  `ws`: word to serialize.
- `iValid`  in  1: `iData` is offered this cycle.
- `oReady`  out  1: FIFO can accept a word; a push occurs at a falling edge with `iValid && oReady`.
- `oBit`  out  1: serial data bit, registered.
- `oBitValid`  out  1: `oBit` carries a data bit this cycle.
- `oFrame`  out  1: high only while `oBit` is bit 0 of a word.
- `oCount`  out  `AW+1`: FIFO occupancy, 0..`DEPTH`.

## Operation
- FIFO:
  - Circular buffer with read and write pointers of `AW` bits and a count of `AW+1` bits.
  - Pointers wrap modulo `DEPTH`.
  - `oReady` = (count < `DEPTH`), derived from the registered count.
  - A push while full cannot occur; a pop while empty cannot occur.
- Count update on each edge: push only +1; pop only −1; push and pop together leaves the count unchanged.
- Shifter state machine, two states:
  - IDLE: outputs `oBitValid`=0, `oBit`=0, `oFrame`=0. At an edge with count > 0 (registered count, i.e. before this edge's push), load the head word into the shift register, pop it, set index=0, and go to SHIFT.
  - SHIFT: `oBit` = shift[0]; `oBitValid`=1; `oFrame`=1 when index==0.
  - SHIFT, each edge with index < `ws`−1: shift right by one and increment the index.
  - SHIFT, edge with index == `ws`−1: if count > 0, load and pop the next word and set index=0, staying in SHIFT with no gap. Otherwise go to IDLE.
- Index width is `$clog2(ws)` bits. The index compares against `ws`−1 and never wraps silently.
- Bit order: `iData[k]` appears on `oBit` in the k-th cycle of its frame.
- A word pushed into an empty FIFO while in IDLE is not loaded on the same edge; the load uses the pre-edge count.
- Reset, asynchronous, including mid-word:
  - FIFO is emptied and pointers are cleared.
  - State goes to IDLE and the index is cleared.
  - `oBit`=0, `oBitValid`=0, `oFrame`=0, `oCount`=0, `oReady`=1.
  - Any partly sent word is discarded. No bits are emitted until a new push.

## Timing
- Push accepted at edge N into an empty FIFO with the shifter IDLE:
  - The word is loaded at edge N+1.
  - Bit 0 is valid after edge N+1 with `oFrame`=1.
  - Bit `ws`−1 is valid after edge N+`ws`.
- A word loaded at edge L shows bit k after edge L+k. The next load, or return to IDLE, happens at edge L+`ws`.
- Sustained throughput is 1 bit per cycle. `oFrame` pulses exactly every `ws` cycles while the FIFO stays non-empty.
- `oReady` rises in the cycle after the edge that pops from a full FIFO.
- `oCount` reflects the count after each edge and has no combinational path from `iValid`.

## Test plan
- Reset: hold `iRST_N`=0 with `iValid`=1 → `oBit`=0, `oBitValid`=0, `oFrame`=0, `oCount`=0, `oReady`=1, and no push.
- Single word 0xA5C3 pushed at edge N:
  - `oBit` sequence after edges N+1..N+16 is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `oFrame` is high only after N+1.
  - `oBitValid`=0 after N+17.
- Fill, with 6 words 0x0001, 0x8000, 0xFFFF, 0x0000, 0x1234, 0xBEEF offered on consecutive edges 1..6:
  - Word 1 loads at edge 2.
  - Count reaches 4 at edge 5, and `oReady`=0 from edge 5.
  - 0xBEEF is held until `oReady` rises after edge 18 and is accepted at edge 19.
  - Serial stream is 96 contiguous valid bits with `oFrame` at 2, 18, 34, 50, 66, 82.
- Simultaneous push and pop: with count=1 and the shifter at index `ws`−1, push at that edge → `oCount` stays 1, the next frame starts with no gap, and `oFrame` is high.
- Reset mid-word:
  - Drop `iRST_N` asynchronously while bit 7 of 0x00FF is shown → outputs clear immediately and `oCount`=0.
  - After release with no push, `oBitValid` stays 0 for 20 cycles.

Source files
------------

// File: rtl/rand_serializer.sv
// rand_serializer: buffers ws-bit words in a small FIFO and emits them one
// bit per clock, LSB first, as back-to-back frames of ws bits. All state
// advances on the falling edge of iCLK.
module rand_serializer #(
  parameter int ws    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [ws-1:0] iData,
  input  logic          iValid,
  output logic          oReady,
  output logic          oBit,
  output logic          oBitValid,
  output logic          oFrame,
  output logic [AW:0]   oCount
);

  localparam int            IW       = $clog2(ws);
  localparam logic [IW-1:0] LAST_IDX = IW'(ws - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } stateT;

  stateT          state;
  stateT          nextState;
  logic [ws-1:0]  mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic [AW:0]    count;
  logic [ws-1:0]  shiftReg;
  logic [IW-1:0]  bitIdx;
  logic           push;
  logic           pop;
  logic           atLast;

  // Handshake and status come straight from registered state, so there is
  // no combinational path from iValid to oReady or oCount.
  assign oReady = (count < FULL_CNT);
  assign oCount = count;
  assign push   = iValid && oReady;
  assign atLast = (bitIdx == LAST_IDX);

  // Next-state, pop decision and serial outputs. The load decision uses the
  // pre-edge count, so a word pushed into an empty FIFO waits one edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    nextState = state;
    pop       = 1'b0;
    oBit      = 1'b0;
    oBitValid = 1'b0;
    oFrame    = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        oBit      = shiftReg[0];
        oBitValid = 1'b1;
        oFrame    = (bitIdx == '0);
        if (atLast) begin
          if (count != '0) pop = 1'b1;
          else             nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(negedge iCLK or negedge iRST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  // FIFO storage; written only on an accepted push.
  always_ff @(negedge iCLK) begin
    // NOTE: the word array is deliberately not reset; count and pointers
    // define which entries are valid, so stale contents are never read.
    if (push) mem[wrPtr] <= iData;
  end

  // FIFO pointers and occupancy.
  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Shift register and bit index: load on pop, otherwise shift right until
  // the last bit of the frame has been shown.
  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      shiftReg <= '0;
      bitIdx   <= '0;
    end else if (pop) begin
      shiftReg <= mem[rdPtr];
      bitIdx   <= '0;
    end else if (state == SHIFT) begin
      if (!atLast) begin
        shiftReg <= shiftReg >> 1;
        bitIdx   <= bitIdx + IW'(1);
      end else begin
        bitIdx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rand_serializer.sv
// tb_rand_serializer: directed self-checking bench for rand_serializer.
// Outputs are sampled 1 time unit after each falling (active) edge; inputs
// are changed at the same point, well clear of the next active edge.
module tb_rand_serializer;

  localparam int WS    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          iCLK;
  logic          iRST_N;
  logic [WS-1:0] iData;
  logic          iValid;
  logic          oReady;
  logic          oBit;
  logic          oBitValid;
  logic          oFrame;
  logic [AW:0]   oCount;

  int testsRun  = 0;
  int failCount = 0;

  rand_serializer #(.ws(WS), .DEPTH(DEPTH), .AW(AW)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iData     (iData),
    .iValid    (iValid),
    .oReady    (oReady),
    .oBit      (oBit),
    .oBitValid (oBitValid),
    .oFrame    (oFrame),
    .oCount    (oCount)
  );

  initial iCLK = 1'b1;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active (falling) edge and settle.
  task automatic nextEdge();
    @(negedge iCLK);
    #1;
  endtask

  // Expected LSB-first stream of 0xA5C3.
  int a5c3Seq [16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
  logic [WS-1:0] fillWords [6] = '{16'h0001, 16'h8000, 16'hFFFF,
                                   16'h0000, 16'h1234, 16'hBEEF};

  initial begin
    logic          rdy;
    logic [WS-1:0] w;
    int            idx;
    int            acceptEdge;

    // ---- Reset held with iValid asserted: nothing is pushed ----
    iRST_N = 1'b0;
    iValid = 1'b1;
    iData  = 16'hFFFF;
    repeat (3) nextEdge();
    check("rst_bit",      oBit,      1'b0);
    check("rst_bitvalid", oBitValid, 1'b0);
    check("rst_frame",    oFrame,    1'b0);
    check("rst_count",    oCount,    3'd0);
    check("rst_ready",    oReady,    1'b1);
    iValid = 1'b0;
    iData  = '0;
    iRST_N = 1'b1;
    repeat (2) nextEdge();
    check("post_rst_count",    oCount,    3'd0);
    check("post_rst_bitvalid", oBitValid, 1'b0);

    // ---- Single word 0xA5C3 ----
    iValid = 1'b1;
    iData  = 16'hA5C3;
    nextEdge();                        // edge N: push
    iValid = 1'b0;
    iData  = '0;
    check("single_count_after_push", oCount,    3'd1);
    check("single_no_same_edge_load", oBitValid, 1'b0);
    for (int k = 0; k < WS; k++) begin
      nextEdge();                      // edge N+1+k
      check($sformatf("single_bit%0d", k),   oBit,      a5c3Seq[k][0]);
      check($sformatf("single_valid%0d", k), oBitValid, 1'b1);
      check($sformatf("single_frame%0d", k), oFrame,    (k == 0));
    end
    nextEdge();                        // edge N+17
    check("single_idle_valid", oBitValid, 1'b0);
    check("single_idle_frame", oFrame,    1'b0);
    check("single_idle_count", oCount,    3'd0);

    // ---- Fill: six words offered from edge 1, FIFO saturates ----
    idx        = 0;
    acceptEdge = -1;
    iValid     = 1'b1;
    iData      = fillWords[0];
    for (int e = 1; e <= 98; e++) begin
      rdy = oReady;
      nextEdge();
      if (iValid && rdy) begin
        idx++;
        if (idx == 6) acceptEdge = e;
      end
      iValid = (idx < 6);
      iData  = (idx < 6) ? fillWords[idx] : '0;
      if (e == 5) check("fill_count_full", oCount, 3'd4);
      if (e >= 5 && e <= 18)
        check($sformatf("fill_ready_e%0d", e), oReady, (e == 18));
      if (e >= 2 && e <= 97) begin
        w = fillWords[(e - 2) / WS];
        check($sformatf("fill_bit_e%0d", e),   oBit,      w[(e - 2) % WS]);
        check($sformatf("fill_valid_e%0d", e), oBitValid, 1'b1);
        check($sformatf("fill_frame_e%0d", e), oFrame,    ((e - 2) % WS == 0));
      end
      if (e == 98) begin
        check("fill_end_valid", oBitValid, 1'b0);
        check("fill_end_count", oCount,    3'd0);
      end
    end
    check("fill_beef_accept_edge", acceptEdge, 19);

    // ---- Simultaneous push and pop on the last bit of a frame ----
    iValid = 1'b1;
    iData  = 16'h8001;                 // A
    nextEdge();                        // e1: push A
    iValid = 1'b0;
    nextEdge();                        // e1+1: load A
    iValid = 1'b1;
    iData  = 16'h3332;                 // B, bit0 = 0
    nextEdge();                        // e1+2: push B
    iValid = 1'b0;
    repeat (14) nextEdge();            // through e1+16: A bit 15 shown
    check("sim_pre_bit15",   oBit,   1'b1);
    check("sim_pre_count",   oCount, 3'd1);
    check("sim_pre_frame",   oFrame, 1'b0);
    iValid = 1'b1;
    iData  = 16'h0F0F;                 // C
    nextEdge();                        // e1+17: pop B and push C
    iValid = 1'b0;
    iData  = '0;
    check("sim_count_holds", oCount,    3'd1);
    check("sim_frame",       oFrame,    1'b1);
    check("sim_valid",       oBitValid, 1'b1);
    check("sim_bit0_of_b",   oBit,      1'b0);
    nextEdge();
    check("sim_bit1_of_b",   oBit,      1'b1);
    repeat (40) nextEdge();
    check("sim_drain_valid", oBitValid, 1'b0);
    check("sim_drain_count", oCount,    3'd0);

    // ---- Asynchronous reset mid-word ----
    iValid = 1'b1;
    iData  = 16'h00FF;
    nextEdge();                        // N: push 0x00FF
    iData  = 16'hFFFF;
    nextEdge();                        // N+1: load 0x00FF, push 0xFFFF
    iValid = 1'b0;
    iData  = '0;
    repeat (7) nextEdge();             // N+8: bit 7 shown
    check("mid_bit7",       oBit,      1'b1);
    check("mid_valid",      oBitValid, 1'b1);
    check("mid_count",      oCount,    3'd1);
    #1 iRST_N = 1'b0;
    #1;
    check("mid_rst_bit",    oBit,      1'b0);
    check("mid_rst_valid",  oBitValid, 1'b0);
    check("mid_rst_frame",  oFrame,    1'b0);
    check("mid_rst_count",  oCount,    3'd0);
    check("mid_rst_ready",  oReady,    1'b1);
    #1 iRST_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      nextEdge();
      check($sformatf("mid_quiet_valid%0d", c), oBitValid, 1'b0);
    end
    check("mid_quiet_count", oCount, 3'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
